// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - parametrised SPI master transmitter with one-deep buffer and burst frames
module spi_master_tx #(
    parameter int DATA_LENGTH = 8,
    parameter int CLK_DIV     = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int NUM_SLAVES  = 1,
    parameter int SS_LEAD     = 2,
    parameter int SS_LAG      = 2,
    parameter int SS_IDLE     = 2,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                   SCLK,
    input  logic                   RST_N,
    input  logic [DATA_LENGTH-1:0] DATA,
    input  logic [SW-1:0]          SLAVE_SEL,
    input  logic                   HOLD,
    input  logic                   VALID,
    output logic                   READY,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   MCLK,
    output logic [NUM_SLAVES-1:0]  SS_N,
    output logic                   MISO
);

    localparam int EW   = $clog2(2 * DATA_LENGTH);
    localparam int HW   = $clog2(CLK_DIV) + 1;
    localparam int TMAX = (SS_LEAD > SS_LAG) ? ((SS_LEAD > SS_IDLE) ? SS_LEAD : SS_IDLE)
                                             : ((SS_LAG > SS_IDLE) ? SS_LAG : SS_IDLE);
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [EW-1:0] E_LAST    = EW'(2 * DATA_LENGTH - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LEAD_LAST = TW'(SS_LEAD - 1);
    localparam logic [TW-1:0] LAG_LAST  = TW'(SS_LAG - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(SS_IDLE - 1);
    localparam logic          MCLK_IDLE = (CPOL != 0);

    typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_LAG, ST_GAP} state_t;

    state_t                  state, state_d;
    logic [TW-1:0]           tcnt, tcnt_d;
    logic [HW-1:0]           hcnt, hcnt_d;
    logic [EW-1:0]           ecnt, ecnt_d;
    logic [DATA_LENGTH-1:0]  shreg, shreg_d;
    logic                    miso_q, miso_d;
    logic                    mclk_q, mclk_d;
    logic [NUM_SLAVES-1:0]   ss_n_q, ss_n_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;

    logic                    buf_valid, buf_valid_d, buf_take;
    logic [DATA_LENGTH-1:0]  buf_data;
    logic [SW-1:0]           buf_sel;
    logic                    buf_hold;
    logic                    ready_q;
    logic                    accept;
    logic                    advance;

    function automatic logic head_bit(input logic [DATA_LENGTH-1:0] d);
        return (LSB_FIRST != 0) ? d[0] : d[DATA_LENGTH-1];
    endfunction

    function automatic logic [DATA_LENGTH-1:0] shift_next(input logic [DATA_LENGTH-1:0] d);
        return (LSB_FIRST != 0) ? (d >> 1) : (d << 1);
    endfunction

    // Out-of-range selects decode to no active line
    function automatic logic [NUM_SLAVES-1:0] ss_decode(input logic [SW-1:0] s);
        logic [NUM_SLAVES-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s == SW'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign accept      = VALID && ready_q;
    assign buf_valid_d = (buf_valid && !buf_take) || accept;
    assign advance     = (CPHA == 0) ? ecnt[0] : (!ecnt[0] && (ecnt != '0));

    always_comb begin
        state_d  = state;
        tcnt_d   = tcnt;
        hcnt_d   = hcnt;
        ecnt_d   = ecnt;
        shreg_d  = shreg;
        miso_d   = miso_q;
        mclk_d   = mclk_q;
        ss_n_d   = ss_n_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        buf_take = 1'b0;
        case (state)
            ST_IDLE: begin
                miso_d = 1'b0;
                mclk_d = MCLK_IDLE;
                if (buf_valid) begin
                    buf_take = 1'b1;
                    shreg_d  = buf_data;
                    miso_d   = head_bit(buf_data);
                    sel_d    = buf_sel;
                    hold_d   = buf_hold;
                    ss_n_d   = ss_decode(buf_sel);
                    tcnt_d   = '0;
                    state_d  = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tcnt == LEAD_LAST) begin
                    tcnt_d  = '0;
                    hcnt_d  = '0;
                    ecnt_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            ST_SHIFT: begin
                if (hcnt == H_LAST) begin
                    hcnt_d = '0;
                    mclk_d = ~mclk_q;
                    ecnt_d = ecnt + EW'(1);
                    if (ecnt == E_LAST) begin
                        done_d = 1'b1;
                        mclk_d = MCLK_IDLE;
                        ecnt_d = '0;
                        // Chain into the next frame without releasing the select
                        if (buf_valid && hold_q && (buf_sel == sel_q)) begin
                            buf_take = 1'b1;
                            shreg_d  = buf_data;
                            miso_d   = head_bit(buf_data);
                            hold_d   = buf_hold;
                        end else begin
                            tcnt_d  = '0;
                            state_d = ST_LAG;
                        end
                    end else if (advance) begin
                        shreg_d = shift_next(shreg);
                        miso_d  = head_bit(shift_next(shreg));
                    end
                end else begin
                    hcnt_d = hcnt + HW'(1);
                end
            end
            ST_LAG: begin
                if (tcnt == LAG_LAST) begin
                    ss_n_d  = '1;
                    miso_d  = 1'b0;
                    tcnt_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            ST_GAP: begin
                if (tcnt == IDLE_LAST) begin
                    tcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            hcnt      <= '0;
            ecnt      <= '0;
            shreg     <= '0;
            miso_q    <= 1'b0;
            mclk_q    <= MCLK_IDLE;
            ss_n_q    <= '1;
            sel_q     <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_sel   <= '0;
            buf_hold  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= state_d;
            tcnt      <= tcnt_d;
            hcnt      <= hcnt_d;
            ecnt      <= ecnt_d;
            shreg     <= shreg_d;
            miso_q    <= miso_d;
            mclk_q    <= mclk_d;
            ss_n_q    <= ss_n_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            buf_valid <= buf_valid_d;
            ready_q   <= !buf_valid_d;
            if (accept) begin
                buf_data <= DATA;
                buf_sel  <= SLAVE_SEL;
                buf_hold <= HOLD;
            end
        end
    end

    assign READY = ready_q;
    assign BUSY  = (state != ST_IDLE);
    assign DONE  = done_q;
    assign MCLK  = mclk_q;
    assign SS_N  = ss_n_q;
    assign MISO  = miso_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - randomized bench for spi_master_tx over several modes against a frame timeline model
module tb_spi_master_tx;

    localparam int NI   = 6;
    localparam int NCYC = 3000;
    localparam int MAXC = NCYC + 200;

    logic sclk = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   fin_cnt = 0;

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int N      = (g == 5) ? 5 : 8;
        localparam int CD     = (g == 0) ? 2 : ((g == 5) ? 1 : 3);
        localparam int MODE   = (g >= 1 && g <= 4) ? g - 1 : 0;
        localparam int CPOL_P = MODE / 2;
        localparam int CPHA_P = MODE % 2;
        localparam int LSB_P  = (g >= 1 && g <= 4) ? 1 : 0;
        localparam int NS     = (g == 0) ? 3 : ((g == 5) ? 2 : 1);
        localparam int SW     = (NS > 1) ? $clog2(NS) : 1;
        localparam int LEAD   = 1 + (g % 3);
        localparam int LAG    = 1 + ((g + 1) % 3);
        localparam int IDL    = 1 + ((g + 2) % 3);

        logic          rst_n, valid, hold, ready, busy, done, mclk, miso;
        logic [N-1:0]  data;
        logic [SW-1:0] sel;
        logic [NS-1:0] ss_n;

        spi_master_tx #(
            .DATA_LENGTH(N), .CLK_DIV(CD), .CPOL(CPOL_P), .CPHA(CPHA_P), .LSB_FIRST(LSB_P),
            .NUM_SLAVES(NS), .SS_LEAD(LEAD), .SS_LAG(LAG), .SS_IDLE(IDL)
        ) u_dut (
            .SCLK(sclk), .RST_N(rst_n), .DATA(data), .SLAVE_SEL(sel), .HOLD(hold),
            .VALID(valid), .READY(ready), .BUSY(busy), .DONE(done), .MCLK(mclk),
            .SS_N(ss_n), .MISO(miso)
        );

        // Expected output value during the cycle after each SCLK edge t
        logic          e_mclk [MAXC];
        logic          e_miso [MAXC];
        logic          e_ready[MAXC];
        logic          e_busy [MAXC];
        logic          e_done [MAXC];
        logic [NS-1:0] e_ss   [MAXC];

        bit            have_prev;
        int            prev_e, prev_g;
        logic          prev_hold;
        logic [SW-1:0] prev_sel;
        int            rst_at, nwords, rst_cnt;
        bit            accepted;

        task automatic clear_model(input int from);
            for (int x = from; x < MAXC; x++) begin
                e_mclk[x]  = 1'(CPOL_P);
                e_miso[x]  = 1'b0;
                e_ready[x] = 1'b1;
                e_busy[x]  = 1'b0;
                e_done[x]  = 1'b0;
                e_ss[x]    = '1;
            end
            have_prev = 0;
            prev_e    = -100;
            prev_g    = -100;
        endtask

        function automatic logic bit_at(input logic [N-1:0] d, input int i);
            return (LSB_P != 0) ? d[i] : d[N-1-i];
        endfunction

        task automatic schedule(input int a, input logic [N-1:0] d, input logic [SW-1:0] s, input logic h);
            int p, st, e, gp, k;
            logic [NS-1:0] ssv;
            if (have_prev && prev_hold && (s == prev_sel) && (a < prev_e)) begin
                p  = prev_e;
                st = prev_e;
            end else begin
                p  = (a + 1 > prev_g + 1) ? a + 1 : prev_g + 1;
                st = p + LEAD;
            end
            e  = st + 2 * N * CD;
            gp = e + LAG + IDL;
            ssv = '1;
            for (int i = 0; i < NS; i++) if (int'(s) == i) ssv[i] = 1'b0;
            for (int x = a; x < p && x < MAXC; x++) e_ready[x] = 1'b0;
            for (int x = p; x < gp && x < MAXC; x++) e_busy[x] = 1'b1;
            for (int x = p; x < e + LAG && x < MAXC; x++) begin
                e_ss[x]   = ssv;
                e_miso[x] = bit_at(d, 0);
            end
            for (int i = 1; i < N; i++) begin
                k = (CPHA_P != 0) ? 2 * i + 1 : 2 * i;
                for (int x = st + k * CD; x < e + LAG && x < MAXC; x++) e_miso[x] = bit_at(d, i);
            end
            for (int j = 1; j < 2 * N; j++) begin
                for (int x = st + j * CD; x < st + (j + 1) * CD && x < MAXC; x++)
                    e_mclk[x] = 1'(CPOL_P) ^ 1'(j % 2);
            end
            if (e < MAXC) e_done[e] = 1'b1;
            if (nwords == 4) rst_at = st + 8 * CD;
            have_prev = 1;
            prev_e    = e;
            prev_g    = gp;
            prev_hold = h;
            prev_sel  = s;
        endtask

        task automatic check_reset_outputs(input string when);
            check($sformatf("i%0d %s ready", g, when), 32'(ready), 32'd1);
            check($sformatf("i%0d %s busy", g, when), 32'(busy), 32'd0);
            check($sformatf("i%0d %s done", g, when), 32'(done), 32'd0);
            check($sformatf("i%0d %s mclk", g, when), 32'(mclk), 32'(CPOL_P));
            check($sformatf("i%0d %s ss_n", g, when), 32'(ss_n), 32'((1 << NS) - 1));
            check($sformatf("i%0d %s miso", g, when), 32'(miso), 32'd0);
        endtask

        initial begin
            rst_n = 1'b0; valid = 1'b0; data = '0; sel = '0; hold = 1'b0;
            nwords = 0; rst_at = -1; rst_cnt = 0;
            clear_model(0);
            repeat (2) @(posedge sclk);
            #1;
            check_reset_outputs("reset");
            rst_n = 1'b1;
            for (int t = 0; t < NCYC; t++) begin
                @(posedge sclk);
                accepted = 0;
                if (valid && rst_n && ((t == 0) ? 1'b1 : e_ready[t-1])) begin
                    schedule(t, data, sel, hold);
                    nwords++;
                    accepted = 1;
                end
                #1;
                check($sformatf("i%0d ready t%0d", g, t), 32'(ready), 32'(e_ready[t]));
                check($sformatf("i%0d busy t%0d", g, t), 32'(busy), 32'(e_busy[t]));
                check($sformatf("i%0d done t%0d", g, t), 32'(done), 32'(e_done[t]));
                check($sformatf("i%0d mclk t%0d", g, t), 32'(mclk), 32'(e_mclk[t]));
                check($sformatf("i%0d ss_n t%0d", g, t), 32'(ss_n), 32'(e_ss[t]));
                check($sformatf("i%0d miso t%0d", g, t), 32'(miso), 32'(e_miso[t]));
                if (t == rst_at) begin
                    rst_n = 1'b0;
                    valid = 1'b0;
                    #1;
                    check_reset_outputs("midreset");
                    clear_model(t + 1);
                    rst_cnt = 2;
                end else if (rst_cnt > 0) begin
                    rst_cnt--;
                    if (rst_cnt == 0) rst_n = 1'b1;
                end
                if (accepted) valid = 1'b0;
                if (!valid && rst_n && t < NCYC - 300) begin
                    if (nwords < 10 || $urandom_range(99) < 40) begin
                        valid = 1'b1;
                        data  = N'($urandom);
                        hold  = ($urandom_range(3) != 0);
                        if ($urandom_range(3) == 0) sel = SW'($urandom);
                    end
                end
            end
            fin_cnt++;
        end
    end

    initial begin
        repeat (NCYC + 20) @(posedge sclk);
        #2;
        check("instances finished", 32'(fin_cnt), 32'(NI));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
